xgriscv_mdu_iter: RTL and testbench

//   Iterative multiply/divide unit for the EX stage; adds RV32M to the 5-stage pipeline.

---
 rtl/xgriscv_mdu_iter.sv | 190 +++++++++++++++++++
 tb/tb_xgriscv_mdu_iter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xgriscv_mdu_iter.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, UNROLL bits per CALC cycle,
// with a FIX cycle for sign correction and a single-cycle DONE pulse.
module xgriscv_mdu_iter #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1,
    parameter int unsigned RFIDX  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [RFIDX-1:0] rd_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [XLEN-1:0]  result_o,
    output logic [RFIDX-1:0] rd_o
);

    localparam int unsigned ITER = XLEN / UNROLL;
    localparam int unsigned CNTW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned PW   = 2 * XLEN;
    localparam logic [XLEN-1:0] MINVAL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNTW-1:0] LASTCNT = CNTW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, nextState;

    logic [2:0]       opR;
    logic             signR;
    logic [RFIDX-1:0] rdR;
    logic [XLEN-1:0]  magB;
    logic [PW-1:0]    prod;     // product, or quotient in the low half when dividing
    logic [XLEN-1:0]  rem;
    logic [CNTW-1:0]  cnt;

    logic             accept;
    logic             aSigned, bSigned, sa, sb, signIn;
    logic [XLEN-1:0]  magA, magBIn;
    logic             divZero, ovf, special;
    logic [XLEN-1:0]  specVal;

    logic [PW-1:0]    prodNext;
    logic [XLEN-1:0]  remNext;
    logic [XLEN:0]    trial;
    logic [XLEN:0]    sum;
    logic             qBit;

    logic [PW-1:0]    prodSigned;
    logic [XLEN-1:0]  divSel;
    logic [XLEN-1:0]  fixVal;

    // Operand decode at the accept edge: magnitudes, result sign, special cases
    always_comb begin
        accept  = (state == IDLE) && valid_i && !flush_i;
        aSigned = op_i[2] ? !op_i[0] : (op_i[1:0] != 2'd3);
        bSigned = op_i[2] ? !op_i[0] : !op_i[1];
        sa      = aSigned & a_i[XLEN-1];
        sb      = bSigned & b_i[XLEN-1];
        magA    = sa ? -a_i : a_i;
        magBIn  = sb ? -b_i : b_i;
        signIn  = (op_i[2] && op_i[1]) ? sa : (sa ^ sb);
        divZero = op_i[2] && (b_i == '0);
        ovf     = op_i[2] && !op_i[0] && (a_i == MINVAL) && (b_i == '1);
        special = divZero || ovf;
        if (divZero) begin
            specVal = op_i[1] ? a_i : '1;
        end else begin
            specVal = op_i[1] ? '0 : a_i;
        end
    end

    // One CALC cycle: UNROLL shift-add or restoring-divide steps
    always_comb begin
        prodNext = prod;
        remNext  = rem;
        trial    = '0;
        sum      = '0;
        qBit     = 1'b0;
        for (int i = 0; i < int'(UNROLL); i++) begin
            if (opR[2]) begin
                trial = {remNext, prodNext[XLEN-1]};
                qBit  = (trial >= {1'b0, magB});
                remNext = qBit ? XLEN'(trial - {1'b0, magB}) : trial[XLEN-1:0];
                prodNext[XLEN-1:0] = {prodNext[XLEN-2:0], qBit};
            end else begin
                sum = {1'b0, prodNext[PW-1:XLEN]} + (prodNext[0] ? {1'b0, magB} : '0);
                prodNext = {sum, prodNext[XLEN-1:1]};
            end
        end
    end

    // Sign correction and half/quotient/remainder selection in FIX
    always_comb begin
        prodSigned = signR ? -prod : prod;
        divSel     = opR[1] ? rem : prod[XLEN-1:0];
        if (opR[2]) begin
            fixVal = signR ? -divSel : divSel;
        end else if (opR[1:0] == 2'd0) begin
            fixVal = prodSigned[XLEN-1:0];
        end else begin
            fixVal = prodSigned[PW-1:XLEN];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and stall decode; flush overrides everything
    always_comb begin
        nextState = state;
        stall_o   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    stall_o   = 1'b1;
                    nextState = special ? DONE : CALC;
                end
            end
            CALC: begin
                stall_o = 1'b1;
                if (cnt == LASTCNT) begin
                    nextState = FIX;
                end
            end
            FIX: begin
                stall_o   = 1'b1;
                nextState = DONE;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (flush_i) begin
            nextState = IDLE;
        end
    end

    assign done_o = (state == DONE);

    // Datapath registers and result capture on entry to DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opR      <= '0;
            signR    <= 1'b0;
            rdR      <= '0;
            magB     <= '0;
            prod     <= '0;
            rem      <= '0;
            cnt      <= '0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            if (accept) begin
                opR   <= op_i;
                signR <= signIn;
                rdR   <= rd_i;
                magB  <= magBIn;
                prod  <= {XLEN'(0), magA};
                rem   <= '0;
                cnt   <= '0;
            end else if (state == CALC) begin
                prod <= prodNext;
                rem  <= remNext;
                cnt  <= cnt + CNTW'(1);
            end
            if (accept && special) begin
                result_o <= specVal;
                rd_o     <= rd_i;
            end else if ((state == FIX) && !flush_i) begin
                result_o <= fixVal;
                rd_o     <= rdR;
            end
        end
    end

endmodule

// File: tb/tb_xgriscv_mdu_iter.sv
// Scoreboard bench for xgriscv_mdu_iter: one instance with UNROLL=1, one with UNROLL=4.
module tb_xgriscv_mdu_iter;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        validS [2];
    logic [2:0]  opS    [2];
    logic [31:0] aS     [2];
    logic [31:0] bS     [2];
    logic [4:0]  rdS    [2];
    logic        flushS [2];

    logic        stall0, done0, stall1, done1;
    logic [31:0] res0, res1;
    logic [4:0]  rdo0, rdo1;

    logic [36:0] sb0 [$];
    logic [36:0] sb1 [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    xgriscv_mdu_iter #(.XLEN(32), .UNROLL(1), .RFIDX(5)) dut1 (
        .clk(clk), .reset(reset), .valid_i(validS[0]), .op_i(opS[0]), .a_i(aS[0]), .b_i(bS[0]),
        .rd_i(rdS[0]), .flush_i(flushS[0]), .stall_o(stall0), .done_o(done0),
        .result_o(res0), .rd_o(rdo0)
    );

    xgriscv_mdu_iter #(.XLEN(32), .UNROLL(4), .RFIDX(5)) dut4 (
        .clk(clk), .reset(reset), .valid_i(validS[1]), .op_i(opS[1]), .a_i(aS[1]), .b_i(bS[1]),
        .rd_i(rdS[1]), .flush_i(flushS[1]), .stall_o(stall1), .done_o(done1),
        .result_o(res1), .rd_o(rdo1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic stallOf(input int idx);
        return (idx == 0) ? stall0 : stall1;
    endfunction

    function automatic logic doneOf(input int idx);
        return (idx == 0) ? done0 : done1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushExp(input int idx, input logic [31:0] exp, input logic [4:0] rd);
        if (idx == 0) sb0.push_back({exp, rd});
        else          sb1.push_back({exp, rd});
    endtask

    // Monitor: every done pulse is matched against the oldest expected response
    task automatic checkOut(input int idx, input logic [31:0] r, input logic [4:0] d);
        logic [36:0] e;
        int n;
        n = (idx == 0) ? sb0.size() : sb1.size();
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL dut%0d_unexpected_done: got result=%h rd=%0d expected no done", idx, r, d);
        end else begin
            if (idx == 0) e = sb0.pop_front();
            else          e = sb1.pop_front();
            if ({r, d} !== e) begin
                errors++;
                $display("FAIL dut%0d_result: got result=%h rd=%0d expected result=%h rd=%0d",
                         idx, r, d, e[36:5], e[4:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (done0) checkOut(0, res0, rdo0);
        if (done1) checkOut(1, res1, rdo1);
    end

    // Issue one op from an IDLE cycle; checks latency and stall length, returns in the next IDLE cycle
    task automatic runOp(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int expLat, input string name);
        int lat;
        int stalls;
        validS[idx] = 1'b1;
        opS[idx]    = op;
        aS[idx]     = a;
        bS[idx]     = b;
        rdS[idx]    = rd;
        pushExp(idx, exp, rd);
        @(negedge clk);
        stalls = stallOf(idx) ? 1 : 0;
        @(posedge clk);
        #1 validS[idx] = 1'b0;
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (doneOf(idx)) begin
                lat = i;
                break;
            end
            if (stallOf(idx)) stalls++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(expLat));
        chk({name, "_stall_cycles"}, 32'(stalls), 32'(expLat));
        @(posedge clk);
        #1;
    endtask

    // MUL then DIV with valid held high through DONE; checks pulse spacing and pulse count
    task automatic backToBack(input int idx, input int expGap, input string name);
        int t1;
        int t2;
        int extra;
        t1 = -1000;
        t2 = 0;
        validS[idx] = 1'b1;
        opS[idx] = OP_MUL; aS[idx] = 32'd7; bS[idx] = 32'hFFFF_FFF9; rdS[idx] = 5'd3;
        pushExp(idx, 32'hFFFF_FFCF, 5'd3);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (doneOf(idx)) begin
                t1 = cyc;
                break;
            end
        end
        opS[idx] = OP_DIV; aS[idx] = 32'hFFFF_FFF9; bS[idx] = 32'd2; rdS[idx] = 5'd4;
        pushExp(idx, 32'hFFFF_FFFD, 5'd4);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (doneOf(idx)) begin
                t2 = cyc;
                break;
            end
        end
        validS[idx] = 1'b0;
        chk({name, "_done_gap"}, 32'(t2 - t1), 32'(expGap));
        extra = 0;
        repeat (45) begin
            @(negedge clk);
            if (doneOf(idx)) extra++;
        end
        chk({name, "_extra_done"}, 32'(extra), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            validS[i] = 1'b0; opS[i] = '0; aS[i] = '0; bS[i] = '0; rdS[i] = '0; flushS[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall0", {31'd0, stall0}, 32'd0);
        chk("rst_done0", {31'd0, done0}, 32'd0);
        chk("rst_result0", res0, 32'd0);
        chk("rst_rd0", {27'd0, rdo0}, 32'd0);
        chk("rst_stall1", {31'd0, stall1}, 32'd0);
        chk("rst_result1", res1, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic multiply and high-half products
        runOp(0, OP_MUL,    32'd7,         32'hFFFF_FFF9, 5'd1, 32'hFFFF_FFCF, 34, "mul_7_m7");
        runOp(0, OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 34, "mulh_min");
        runOp(0, OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'hC000_0000, 34, "mulhsu_min");
        runOp(0, OP_MULHU,  32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 34, "mulhu_min");
        runOp(0, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 34, "mulhu_ones");
        runOp(0, OP_MULH,   32'hFFFF_FFFF, 32'd2,         5'd6, 32'hFFFF_FFFF, 34, "mulh_m1_2");
        runOp(0, OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'd1,         34, "mul_m1_m1");

        // Division and remainder signs
        runOp(0, OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 34, "div_m7_2");
        runOp(0, OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 34, "rem_m7_2");
        runOp(0, OP_DIVU, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'h7FFF_FFFC, 34, "divu_big_2");
        runOp(0, OP_DIV,  32'd100,       32'hFFFF_FFF9, 5'd12, 32'hFFFF_FFF2, 34, "div_100_m7");
        runOp(0, OP_REM,  32'd100,       32'hFFFF_FFF9, 5'd13, 32'd2,         34, "rem_100_m7");

        // Special cases finish the cycle after accept
        runOp(0, OP_DIVU, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1, "divu_by0");
        runOp(0, OP_REM,  32'd5,         32'd0,         5'd15, 32'd5,         1, "rem_by0");
        runOp(0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, "div_ovf");
        runOp(0, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1, "rem_ovf");
        runOp(0, OP_DIV,  32'd5,         32'd0,         5'd18, 32'hFFFF_FFFF, 1, "div_by0");
        runOp(0, OP_REMU, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'd1,         34, "remu_big_2");

        // Flush at CALC cycle 10: killed op leaves no done and no result change
        validS[0] = 1'b1; opS[0] = OP_MUL; aS[0] = 32'd3; bS[0] = 32'd4; rdS[0] = 5'd20;
        @(posedge clk);
        #1 validS[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1 flushS[0] = 1'b1;
        @(posedge clk);
        #1 flushS[0] = 1'b0;
        @(negedge clk);
        chk("flush_stall", {31'd0, stall0}, 32'd0);
        chk("flush_done", {31'd0, done0}, 32'd0);
        chk("flush_result_held", res0, 32'd1);
        chk("flush_rd_held", {27'd0, rdo0}, 32'd8);
        @(posedge clk);
        #1;
        runOp(0, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'hFFFF_FFFE, 34, "after_flush");

        // Reset at CALC cycle 5: outputs clear immediately
        validS[0] = 1'b1; opS[0] = OP_DIV; aS[0] = 32'd100; bS[0] = 32'd7; rdS[0] = 5'd22;
        @(posedge clk);
        #1 validS[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, stall0}, 32'd0);
        chk("midrst_done", {31'd0, done0}, 32'd0);
        chk("midrst_result", res0, 32'd0);
        chk("midrst_rd", {27'd0, rdo0}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        runOp(0, OP_DIVU, 32'd100, 32'd7, 5'd23, 32'd14, 34, "after_reset");

        // Back-to-back with valid held, then the UNROLL=4 instance
        backToBack(0, 35, "b2b_u1");
        runOp(1, OP_MUL,  32'd7,         32'hFFFF_FFF9, 5'd1, 32'hFFFF_FFCF, 10, "u4_mul");
        runOp(1, OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd2, 32'hFFFF_FFFD, 10, "u4_div");
        runOp(1, OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'hC000_0000, 10, "u4_mulhsu");
        runOp(1, OP_REM,  32'd100,       32'hFFFF_FFF9, 5'd4, 32'd2,         10, "u4_rem");
        runOp(1, OP_DIVU, 32'd5,         32'd0,         5'd5, 32'hFFFF_FFFF, 1,  "u4_divu_by0");
        backToBack(1, 11, "b2b_u4");

        for (int i = 0; i < 100; i++) begin
            if (sb0.size() == 0 && sb1.size() == 0) break;
            @(negedge clk);
        end
        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
